// File: rtl/demux_bin_stream.sv
// demux_bin_stream
//   Registered stream demultiplexer with binary select. Each accepted input
//   beat is routed to the single output channel named by s_bin. A two-entry
//   buffer (output register + skid register) gives one beat per cycle while
//   keeping s_rdy a pure function of registered state.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active-low
//   s_vld  : input beat valid
//   s_rdy  : input ready (low only when both buffer entries are occupied)
//   s_bin  : binary channel select, sampled with the beat
//   s_dat  : input payload
//   m_vld  : per-channel valid, at most one bit set
//   m_rdy  : per-channel ready
//   m_dat  : payload broadcast to all channels, meaningful where m_vld[i]
//   err    : one-cycle pulse after a beat with s_bin >= WIDTH was dropped
module demux_bin_stream #(
  parameter type         DAT_T     = logic [8-1:0],
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SPLIT     = 4,
  localparam int unsigned WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [WIDTH_LOG-1:0] s_bin,
  input  DAT_T                 s_dat,
  output logic [WIDTH-1:0]     m_vld,
  input  logic [WIDTH-1:0]     m_rdy,
  output DAT_T                 m_dat,
  output logic                 err
);

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH_LOG-1:0] out_bin_q, skid_bin_q;
  DAT_T                 out_dat_q, skid_dat_q;
  logic                 err_q;

  logic        acc;
  logic        in_range;
  logic        in_ok;
  logic        take;
  logic        load_out_s;
  logic        load_out_skid;
  logic        load_skid;
  logic [31:0] bin_grp;
  logic [31:0] bin_mem;

  assign s_rdy    = (state_q != FULL);
  assign acc      = s_vld && s_rdy;
  assign in_range = (32'(s_bin) < WIDTH);
  assign in_ok    = acc && in_range;

  // Two-level select decode: group index and position within a group of
  // SPLIT channels, ANDed per output. Functionally bin == i.
  assign bin_grp = 32'(out_bin_q) / SPLIT;
  assign bin_mem = 32'(out_bin_q) % SPLIT;

  always_comb begin
    m_vld = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      m_vld[i] = (state_q != EMPTY) && (bin_grp == i / SPLIT) && (bin_mem == i % SPLIT);
    end
  end

  // m_vld carries the occupancy, so the take decision needs no indexed lookup
  // of m_rdy by out_bin_q.
  assign take  = |(m_vld & m_rdy);
  assign m_dat = out_dat_q;
  assign err   = err_q;

  always_comb begin
    state_d       = state_q;
    load_out_s    = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_ok) begin
          load_out_s = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (in_ok && !take) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (in_ok && take) begin
          load_out_s = 1'b1;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          load_out_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= acc && !in_range;
    end
  end

  // Payload/select registers carry no reset; they are only observed while
  // the state marks them occupied.
  always_ff @(posedge clk) begin
    if (load_out_s) begin
      out_bin_q <= s_bin;
      out_dat_q <= s_dat;
    end else if (load_out_skid) begin
      out_bin_q <= skid_bin_q;
      out_dat_q <= skid_dat_q;
    end
    if (load_skid) begin
      skid_bin_q <= s_bin;
      skid_dat_q <= s_dat;
    end
  end

endmodule

// File: tb/tb_demux_bin_stream.sv
module tb_demux_bin_stream;

  typedef struct packed {
    logic [3:0] bin;
    logic [7:0] dat;
  } beat_t;

  logic        clk;
  logic        rst_n;

  logic        s_vld;
  logic        s_rdy;
  logic [3:0]  s_bin;
  logic [7:0]  s_dat;
  logic [15:0] m_vld;
  logic [15:0] m_rdy;
  logic [7:0]  m_dat;
  logic        err;

  logic        s_vld12;
  logic        s_rdy12;
  logic [3:0]  s_bin12;
  logic [7:0]  s_dat12;
  logic [11:0] m_vld12;
  logic [11:0] m_rdy12;
  logic [7:0]  m_dat12;
  logic        err12;

  int checks = 0;
  int errors = 0;

  beat_t q[$];

  demux_bin_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_vld (s_vld),
    .s_rdy (s_rdy),
    .s_bin (s_bin),
    .s_dat (s_dat),
    .m_vld (m_vld),
    .m_rdy (m_rdy),
    .m_dat (m_dat),
    .err   (err)
  );

  demux_bin_stream #(
    .WIDTH (12)
  ) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .s_vld (s_vld12),
    .s_rdy (s_rdy12),
    .s_bin (s_bin12),
    .s_dat (s_dat12),
    .m_vld (m_vld12),
    .m_rdy (m_rdy12),
    .m_dat (m_dat12),
    .err   (err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL reset_vld: got %h expected %h", m_vld, 16'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", s_rdy); end
    checks++; if (m_vld12 !== 12'h0) begin errors++; $display("FAIL reset_vld12: got %h expected %h", m_vld12, 12'h0); end
    checks++; if (s_rdy12 !== 1'b1) begin errors++; $display("FAIL reset_rdy12: got %b expected 1", s_rdy12); end
    rst_n = 1'b1;
    step();
    // fill both buffer entries, then reset asynchronously mid-cycle
    m_rdy = '0;
    s_vld = 1'b1; s_bin = 4'd1; s_dat = 8'h11;
    step();
    s_bin = 4'd6; s_dat = 8'h66;
    step();
    s_vld = 1'b0;
    checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL prereset_full: s_rdy got %b expected 0", s_rdy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL async_vld: got %h expected %h", m_vld, 16'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", err); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL async_rdy: got %b expected 1", s_rdy); end
    // handshake attempted while in reset must be ignored
    s_vld = 1'b1; s_bin = 4'd9; s_dat = 8'h99; m_rdy = '1;
    step();
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL inreset_vld: got %h expected %h", m_vld, 16'h0); end
    s_vld = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL postreset_vld[%0d]: got %h expected %h", i, m_vld, 16'h0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL postreset_err[%0d]: got %b expected 0", i, err); end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] ev;
    m_rdy = '1;
    s_vld = 1'b1;
    for (int b = 0; b < 16; b++) begin
      s_bin = 4'(b);
      s_dat = 8'(b);
      step();
      ev = 16'h1 << b;
      checks++; if (m_vld !== ev) begin errors++; $display("FAIL sweep_vld[%0d]: got %h expected %h", b, m_vld, ev); end
      checks++; if (m_dat !== 8'(b)) begin errors++; $display("FAIL sweep_dat[%0d]: got %h expected %h", b, m_dat, 8'(b)); end
      checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL sweep_rdy[%0d]: got %b expected 1", b, s_rdy); end
    end
    s_vld = 1'b0;
    step();
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL sweep_drain: got %h expected %h", m_vld, 16'h0); end
  endtask

  task automatic test_stall();
    m_rdy = '1;
    m_rdy[3] = 1'b0;
    s_vld = 1'b1; s_bin = 4'd3; s_dat = 8'hA1;
    step();
    checks++; if (m_vld !== 16'h0008) begin errors++; $display("FAIL stall_first_vld: got %h expected %h", m_vld, 16'h0008); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL stall_first_rdy: got %b expected 1", s_rdy); end
    s_bin = 4'd5; s_dat = 8'hB2;
    step();
    // offer a third beat while FULL; it must not be taken
    s_bin = 4'd9; s_dat = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL stall_full_rdy[%0d]: got %b expected 0", i, s_rdy); end
      checks++; if (m_vld !== 16'h0008) begin errors++; $display("FAIL stall_full_vld[%0d]: got %h expected %h", i, m_vld, 16'h0008); end
      checks++; if (m_dat !== 8'hA1) begin errors++; $display("FAIL stall_full_dat[%0d]: got %h expected %h", i, m_dat, 8'hA1); end
      step();
    end
    m_rdy[3] = 1'b1;
    step();
    s_vld = 1'b0;
    checks++; if (m_vld !== 16'h0020) begin errors++; $display("FAIL stall_second_vld: got %h expected %h", m_vld, 16'h0020); end
    checks++; if (m_dat !== 8'hB2) begin errors++; $display("FAIL stall_second_dat: got %h expected %h", m_dat, 8'hB2); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL stall_second_rdy: got %b expected 1", s_rdy); end
    step();
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL stall_drain: got %h expected %h", m_vld, 16'h0); end
  endtask

  task automatic test_simultaneous();
    m_rdy = '1;
    s_vld = 1'b1; s_bin = 4'd2; s_dat = 8'h22;
    step();
    checks++; if (m_vld !== 16'h0004) begin errors++; $display("FAIL simul_first_vld: got %h expected %h", m_vld, 16'h0004); end
    s_bin = 4'd7; s_dat = 8'h77;
    step();
    s_vld = 1'b0;
    checks++; if (m_vld !== 16'h0080) begin errors++; $display("FAIL simul_vld: got %h expected %h", m_vld, 16'h0080); end
    checks++; if (m_dat !== 8'h77) begin errors++; $display("FAIL simul_dat: got %h expected %h", m_dat, 8'h77); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL simul_rdy: got %b expected 1", s_rdy); end
    step();
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL simul_drain: got %h expected %h", m_vld, 16'h0); end
  endtask

  task automatic test_out_of_range();
    m_rdy12 = '1;
    m_rdy12[4] = 1'b0;
    s_vld12 = 1'b1; s_bin12 = 4'd4; s_dat12 = 8'h44;
    step();
    checks++; if (m_vld12 !== 12'h010) begin errors++; $display("FAIL oor_hold_vld: got %h expected %h", m_vld12, 12'h010); end
    checks++; if (err12 !== 1'b0) begin errors++; $display("FAIL oor_pre_err: got %b expected 0", err12); end
    s_bin12 = 4'd13; s_dat12 = 8'h5D;
    step();
    checks++; if (err12 !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", err12); end
    checks++; if (m_vld12 !== 12'h010) begin errors++; $display("FAIL oor_vld: got %h expected %h", m_vld12, 12'h010); end
    checks++; if (s_rdy12 !== 1'b1) begin errors++; $display("FAIL oor_rdy: got %b expected 1", s_rdy12); end
    s_bin12 = 4'd2; s_dat12 = 8'h42;
    m_rdy12[4] = 1'b1;
    step();
    s_vld12 = 1'b0;
    checks++; if (err12 !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b expected 0", err12); end
    checks++; if (m_vld12 !== 12'h004) begin errors++; $display("FAIL oor_next_vld: got %h expected %h", m_vld12, 12'h004); end
    checks++; if (m_dat12 !== 8'h42) begin errors++; $display("FAIL oor_next_dat: got %h expected %h", m_dat12, 8'h42); end
    step();
    checks++; if (m_vld12 !== 12'h0) begin errors++; $display("FAIL oor_drain: got %h expected %h", m_vld12, 12'h0); end
  endtask

  task automatic test_random();
    logic [15:0] ev;
    logic        was_full;
    beat_t       nb;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      // outputs now reflect every transfer booked into the model so far
      ev = (q.size() > 0) ? (16'h1 << q[0].bin) : 16'h0;
      checks++; if (m_vld !== ev) begin errors++; $display("FAIL rand_vld[%0d]: got %h expected %h", c, m_vld, ev); end
      checks++; if (s_rdy !== (q.size() < 2)) begin errors++; $display("FAIL rand_rdy[%0d]: got %b expected %b", c, s_rdy, q.size() < 2); end
      checks++; if (!$onehot0(m_vld)) begin errors++; $display("FAIL rand_onehot[%0d]: got %h expected at most one bit", c, m_vld); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err[%0d]: got %b expected 0", c, err); end
      if (q.size() > 0) begin
        checks++; if (m_dat !== q[0].dat) begin errors++; $display("FAIL rand_dat[%0d]: got %h expected %h", c, m_dat, q[0].dat); end
      end
      s_vld = ($urandom_range(0, 3) != 0);
      s_bin = 4'($urandom);
      s_dat = 8'($urandom);
      m_rdy = 16'($urandom);
      was_full = (q.size() >= 2);
      if (q.size() > 0 && m_rdy[q[0].bin]) void'(q.pop_front());
      if (s_vld && !was_full) begin
        nb.bin = s_bin;
        nb.dat = s_dat;
        q.push_back(nb);
      end
      step();
    end
    s_vld = 1'b0;
    m_rdy = '1;
    repeat (3) step();
    checks++; if (m_vld !== 16'h0) begin errors++; $display("FAIL rand_drain: got %h expected %h", m_vld, 16'h0); end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_vld   = 1'b0; s_bin   = '0; s_dat   = '0; m_rdy   = '1;
    s_vld12 = 1'b0; s_bin12 = '0; s_dat12 = '0; m_rdy12 = '1;
    test_reset();
    test_sweep();
    test_stall();
    test_simultaneous();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
